// File: rtl/pipe_ctrl_pkg.sv
// Shared stall masks, FSM states and the stall merge for the pipeline sequencer.
// Stage order in every mask is bit0=PC .. bit5=WB.
package pipe_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
  localparam logic [5:0] STALL_IF   = {{4{NOSTOP}}, {2{STOP}}};
  localparam logic [5:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
  localparam logic [5:0] STALL_EX   = {{2{NOSTOP}}, {4{STOP}}};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, {5{STOP}}};

  typedef enum logic [1:0] {
    PCTRL_IDLE  = 2'd0,
    PCTRL_PEND  = 2'd1,
    PCTRL_FLUSH = 2'd2
  } pctrl_state_e;

  // Deepest requesting stage wins; WB is never held.
  function automatic logic [5:0] stall_merge(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stuck-pipeline watchdog: counts consecutive stalled cycles.
// hang is sticky until reset once the run reaches WDOG_LIMIT.
module stall_wdog #(
  parameter int WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic hang
);

  localparam int RW = $clog2(WDOG_LIMIT + 1);
  localparam logic [RW-1:0] LIM = RW'(WDOG_LIMIT);

  logic [RW-1:0] run;

  // Run counter saturates at the limit; hang latches on the limit-reaching cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= '0;
      hang <= 1'b0;
    end else if (!stalled) begin
      run <= '0;
    end else begin
      if (run != LIM) run <= run + RW'(1);
      if (run == LIM - RW'(1)) hang <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: stall merge, flush/redirect FSM,
// saturating stall-cycle counter and the stuck-pipeline watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stallreq_if_i,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_ex_i,
  input  logic                  stallreq_mem_i,
  input  logic                  flush_req_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  output logic [5:0]            stall_o,
  output logic                  flush_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  flush_ack_o,
  output logic                  flush_busy_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic                  hang_o
);

  pctrl_state_e          state;
  pctrl_state_e          state_nxt;
  logic [ADDR_WIDTH-1:0] pc_lat;
  logic [ADDR_WIDTH-1:0] pc_lat_nxt;
  logic [ADDR_WIDTH-1:0] new_pc_nxt;
  logic                  ack_nxt;
  logic [5:0]            merge;

  // Merged stall vector, suppressed while the flush cycle clears the pipe.
  always_comb begin
    merge   = stall_merge(stallreq_if_i, stallreq_id_i,
                          stallreq_ex_i, stallreq_mem_i);
    stall_o = (state == PCTRL_FLUSH) ? STALL_NONE : merge;
  end

  assign flush_o      = (state == PCTRL_FLUSH);
  assign flush_busy_o = (state != PCTRL_IDLE);

  // Flush sequencing: a flush waits while MEM has an access in flight.
  always_comb begin
    state_nxt  = state;
    pc_lat_nxt = pc_lat;
    new_pc_nxt = new_pc_o;
    ack_nxt    = 1'b0;
    unique case (state)
      PCTRL_IDLE: begin
        if (flush_req_i) begin
          pc_lat_nxt = flush_pc_i;
          ack_nxt    = 1'b1;
          if (stallreq_mem_i) begin
            state_nxt = PCTRL_PEND;
          end else begin
            state_nxt  = PCTRL_FLUSH;
            new_pc_nxt = flush_pc_i;
          end
        end
      end
      PCTRL_PEND: begin
        if (!stallreq_mem_i) begin
          state_nxt  = PCTRL_FLUSH;
          new_pc_nxt = pc_lat;
        end
      end
      PCTRL_FLUSH: state_nxt = PCTRL_IDLE;
      default:     state_nxt = PCTRL_IDLE;
    endcase
  end

  // FSM state, latched redirect target, redirect PC and ack pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= PCTRL_IDLE;
      pc_lat      <= '0;
      new_pc_o    <= '0;
      flush_ack_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_lat      <= pc_lat_nxt;
      new_pc_o    <= new_pc_nxt;
      flush_ack_o <= ack_nxt;
    end
  end

  // Stalled-cycle counter, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((|stall_o) && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

  stall_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .stalled(|stall_o),
    .hang   (hang_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: merge table plus flush,
// watchdog, counter-saturation and reset-mid-flush sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic        freq;
  logic [31:0] fpc;
  logic [5:0]  stall;
  logic        flush, ack, busy, hang;
  logic [31:0] new_pc;
  logic [3:0]  cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(
    .ADDR_WIDTH(32),
    .WDOG_LIMIT(8),
    .CNT_WIDTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stallreq_if_i (req_if),
    .stallreq_id_i (req_id),
    .stallreq_ex_i (req_ex),
    .stallreq_mem_i(req_mem),
    .flush_req_i   (freq),
    .flush_pc_i    (fpc),
    .stall_o       (stall),
    .flush_o       (flush),
    .new_pc_o      (new_pc),
    .flush_ack_o   (ack),
    .flush_busy_o  (busy),
    .stall_cnt_o   (cnt),
    .hang_o        (hang)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       i_if;
    logic       i_id;
    logic       i_ex;
    logic       i_mem;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
    freq = 0; fpc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b001111};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b011111};
    vt[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b001111};
    vt[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};

    // Reset state
    do_reset();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_hang", 32'(hang), 32'h0);

    // Merge table, combinational
    for (int i = 0; i < 10; i++) begin
      req_if  = vt[i].i_if;
      req_id  = vt[i].i_id;
      req_ex  = vt[i].i_ex;
      req_mem = vt[i].i_mem;
      #1;
      chk($sformatf("merge_%0d", i), 32'(stall), 32'(vt[i].exp));
    end

    // Priority: id+mem, drop mem in the same cycle
    do_reset();
    req_id = 1; req_mem = 1;
    #1;
    chk("prio_mem", 32'(stall), 32'h1f);
    req_mem = 0;
    #1;
    chk("prio_id", 32'(stall), 32'h07);

    // Flush without stall
    do_reset();
    freq = 1; fpc = 32'h100;
    step();
    freq = 0; req_id = 1;
    #1;
    chk("fl_flush", 32'(flush), 32'h1);
    chk("fl_newpc", new_pc, 32'h100);
    chk("fl_ack", 32'(ack), 32'h1);
    chk("fl_stall0", 32'(stall), 32'h0);
    chk("fl_busy", 32'(busy), 32'h1);
    step();
    chk("fl_done", 32'(flush), 32'h0);
    chk("fl_ack0", 32'(ack), 32'h0);
    chk("fl_idle", 32'(busy), 32'h0);
    chk("fl_hold", new_pc, 32'h100);
    chk("fl_stall", 32'(stall), 32'h07);

    // Deferred flush behind a MEM stall
    do_reset();
    req_mem = 1; freq = 1; fpc = 32'h200;
    step();
    chk("df_ack", 32'(ack), 32'h1);
    chk("df_busy", 32'(busy), 32'h1);
    chk("df_noflush1", 32'(flush), 32'h0);
    fpc = 32'h300;
    step();
    chk("df_noack2", 32'(ack), 32'h0);
    chk("df_noflush2", 32'(flush), 32'h0);
    freq = 0;
    step();
    req_mem = 0;
    chk("df_noflush3", 32'(flush), 32'h0);
    chk("df_pc_hold", new_pc, 32'h0);
    step();
    chk("df_flush", 32'(flush), 32'h1);
    chk("df_newpc", new_pc, 32'h200);
    chk("df_noack4", 32'(ack), 32'h0);
    step();
    chk("df_end", 32'(flush), 32'h0);
    chk("df_idle", 32'(busy), 32'h0);
    chk("df_pc_keep", new_pc, 32'h200);

    // Watchdog: 7 stalled cycles is short of the limit
    do_reset();
    req_ex = 1;
    repeat (7) step();
    req_ex = 0;
    chk("wd_7", 32'(hang), 32'h0);
    step();
    chk("wd_gap", 32'(hang), 32'h0);
    req_ex = 1;
    repeat (8) step();
    chk("wd_8", 32'(hang), 32'h1);
    req_ex = 0;
    repeat (2) step();
    chk("wd_sticky", 32'(hang), 32'h1);

    // Counter saturation
    do_reset();
    req_if = 1;
    repeat (5) step();
    chk("cnt_5", 32'(cnt), 32'h5);
    repeat (15) step();
    chk("cnt_sat", 32'(cnt), 32'hf);
    req_if = 0;
    step();
    chk("cnt_keep", 32'(cnt), 32'hf);

    // Reset while pending
    do_reset();
    req_mem = 1; freq = 1; fpc = 32'h400;
    step();
    chk("rp_busy", 32'(busy), 32'h1);
    rst = 1; freq = 0; req_mem = 0;
    step();
    rst = 0;
    chk("rp_flush", 32'(flush), 32'h0);
    chk("rp_ack", 32'(ack), 32'h0);
    chk("rp_busy0", 32'(busy), 32'h0);
    chk("rp_newpc", new_pc, 32'h0);
    chk("rp_stall", 32'(stall), 32'h0);
    step();
    chk("rp_noflush", 32'(flush), 32'h0);
    freq = 1; fpc = 32'h500;
    step();
    freq = 0;
    chk("rp_ack2", 32'(ack), 32'h1);
    chk("rp_flush2", 32'(flush), 32'h1);
    chk("rp_newpc2", new_pc, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
